network_interface: RTL and testbench

- Local-port endpoint that sits between a processing core and the router's local port (port 0) of the same node.
- Injection side: buffers core packets, stamps source coordinates and an injection timestamp, and feeds the router's local input FIFO over the data/valid/enable handshake.
- Ejection side: consumes router local-output packets, checks that the destination matches this node, computes network latency and forwards the packet to the core.

---
 rtl/network_interface_if.sv | 31 +++
 rtl/network_interface.sv | 172 +++++++++++++++++
 tb/tb_network_interface.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/network_interface_if.sv
// Core/router handshake bundle for the local-port network interface.
// Packet layout (LSB first): x_dest[3:0], y_dest[3:0], x_source[3:0], y_source[3:0],
// measure[TS_WIDTH], payload[16].
interface network_interface_if #(
  parameter int unsigned TS_WIDTH = 16
);
  localparam int unsigned PktW = 32 + TS_WIDTH;

  logic [PktW-1:0] i_core_data;
  logic            i_core_data_val;
  logic            o_core_en;
  logic [PktW-1:0] o_net_data;
  logic            o_net_data_val;
  logic            i_net_en;
  logic [PktW-1:0] i_net_data;
  logic            i_net_data_val;
  logic            o_net_en;
  logic [PktW-1:0] o_core_data;
  logic            o_core_data_val;
  logic            i_core_en;

  modport slave (
    input  i_core_data, i_core_data_val, i_net_en, i_net_data, i_net_data_val, i_core_en,
    output o_core_en, o_net_data, o_net_data_val, o_net_en, o_core_data, o_core_data_val
  );

  modport master (
    output i_core_data, i_core_data_val, i_net_en, i_net_data, i_net_data_val, i_core_en,
    input  o_core_en, o_net_data, o_net_data_val, o_net_en, o_core_data, o_core_data_val
  );
endinterface

// File: rtl/network_interface.sv
// Local-port network interface: stamped injection FIFO toward the router, destination-checked
// ejection register toward the core. Define NI_LATENCY_STATS_EN for total/max latency outputs.
module network_interface #(
  parameter int unsigned X_LOC     = 0,
  parameter int unsigned Y_LOC     = 0,
  parameter int unsigned INJ_DEPTH = 4,
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  network_interface_if.slave    bus,
  output logic [TS_WIDTH-1:0]   o_latency,
  output logic                  o_dest_error,
  output logic [CNT_WIDTH-1:0]  o_inj_count,
  output logic [CNT_WIDTH-1:0]  o_ej_count
`ifdef NI_LATENCY_STATS_EN
  ,
  output logic [TS_WIDTH+CNT_WIDTH-1:0] o_total_latency,
  output logic [TS_WIDTH-1:0]           o_max_latency
`endif
);

  localparam int unsigned PktW    = 32 + TS_WIDTH;
  localparam int unsigned PtrW    = $clog2(INJ_DEPTH);
  localparam int unsigned MeasLsb = 16;
  localparam logic [3:0]  XLoc    = 4'(X_LOC);
  localparam logic [3:0]  YLoc    = 4'(Y_LOC);

  localparam logic [0:0] InjEmpty  = 1'b0;
  localparam logic [0:0] InjLoaded = 1'b1;
  localparam logic [0:0] EjIdle    = 1'b0;
  localparam logic [0:0] EjHold    = 1'b1;

  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + TS_WIDTH'(1);
  end

  // ---------------- Injection ----------------
  logic [PktW-1:0] mem_q [INJ_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full, empty, push, pop, net_xfer;
  logic [0:0]      inj_state_q, inj_state_d;
  logic [PktW-1:0] net_data_q, stamped;
  logic [CNT_WIDTH-1:0] inj_count_q;
  logic            unused_core_src;

  assign full     = (count_q == (PtrW+1)'(INJ_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.i_core_data_val && !full;
  assign net_xfer = (inj_state_q == InjLoaded) && bus.i_net_en;
  assign pop      = !empty && ((inj_state_q == InjEmpty) || net_xfer);

  // Core-supplied source and measure fields are overwritten by the stamp.
  assign stamped = {bus.i_core_data[PktW-1 -: 16], ts_q, YLoc, XLoc, bus.i_core_data[7:0]};
  assign unused_core_src = ^bus.i_core_data[MeasLsb+TS_WIDTH-1:8];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PtrW+1)'(1);
    else if (!push && pop) count_d = count_q - (PtrW+1)'(1);
  end

  always_comb begin
    inj_state_d = inj_state_q;
    if (pop)           inj_state_d = InjLoaded;
    else if (net_xfer) inj_state_d = InjEmpty;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stamped;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inj_state_q <= InjEmpty;
      net_data_q  <= '0;
      inj_count_q <= '0;
    end else begin
      count_q     <= count_d;
      inj_state_q <= inj_state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        net_data_q <= mem_q[rd_ptr_q];
      end
      if (net_xfer && (inj_count_q != '1)) inj_count_q <= inj_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.o_core_en      = !full;
  assign bus.o_net_data     = net_data_q;
  assign bus.o_net_data_val = (inj_state_q == InjLoaded);
  assign o_inj_count        = inj_count_q;

  // ---------------- Ejection ----------------
  logic [0:0]          ej_state_q, ej_state_d;
  logic [PktW-1:0]     hold_q;
  logic                net_en, accept, dest_ok, capture, handoff;
  logic [TS_WIDTH-1:0] lat, latency_q;
  logic                dest_err_q;
  logic [CNT_WIDTH-1:0] ej_count_q;

  assign net_en  = (ej_state_q == EjIdle) || bus.i_core_en;
  assign accept  = bus.i_net_data_val && net_en;
  assign dest_ok = (bus.i_net_data[3:0] == XLoc) && (bus.i_net_data[7:4] == YLoc);
  assign capture = accept && dest_ok;
  assign handoff = (ej_state_q == EjHold) && bus.i_core_en;
  assign lat     = ts_q - bus.i_net_data[MeasLsb +: TS_WIDTH];

  always_comb begin
    ej_state_d = ej_state_q;
    if (capture)      ej_state_d = EjHold;
    else if (handoff) ej_state_d = EjIdle;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ej_state_q <= EjIdle;
      hold_q     <= '0;
      latency_q  <= '0;
      dest_err_q <= 1'b0;
      ej_count_q <= '0;
    end else begin
      ej_state_q <= ej_state_d;
      if (capture) begin
        hold_q    <= bus.i_net_data;
        latency_q <= lat;
      end
      if (accept && !dest_ok) dest_err_q <= 1'b1;
      if (handoff && (ej_count_q != '1)) ej_count_q <= ej_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.o_net_en        = net_en;
  assign bus.o_core_data     = hold_q;
  assign bus.o_core_data_val = (ej_state_q == EjHold);
  assign o_latency           = latency_q;
  assign o_dest_error        = dest_err_q;
  assign o_ej_count          = ej_count_q;

`ifdef NI_LATENCY_STATS_EN
  localparam int unsigned TotW = TS_WIDTH + CNT_WIDTH;

  logic [TotW-1:0]     total_q;
  logic [TotW:0]       total_sum;
  logic [TS_WIDTH-1:0] max_q;

  assign total_sum = {1'b0, total_q} + (TotW+1)'(lat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q <= '0;
      max_q   <= '0;
    end else if (capture) begin
      total_q <= total_sum[TotW] ? '1 : total_sum[TotW-1:0];
      if (lat > max_q) max_q <= lat;
    end
  end

  assign o_total_latency = total_q;
  assign o_max_latency   = max_q;
`endif

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface: directed scenarios then randomized traffic.
module tb_network_interface;
  localparam int unsigned XL = 3;
  localparam int unsigned YL = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PktW = 32 + TS_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  network_interface_if #(.TS_WIDTH(TS_W)) bus ();
  logic [TS_W-1:0]  o_latency;
  logic             o_dest_error;
  logic [CNT_W-1:0] o_inj_count, o_ej_count;
`ifdef NI_LATENCY_STATS_EN
  logic [TS_W+CNT_W-1:0] o_total_latency;
  logic [TS_W-1:0]       o_max_latency;
`endif

  network_interface #(
    .X_LOC(XL), .Y_LOC(YL), .INJ_DEPTH(DEPTH), .TS_WIDTH(TS_W), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .o_latency    (o_latency),
    .o_dest_error (o_dest_error),
    .o_inj_count  (o_inj_count),
    .o_ej_count   (o_ej_count)
`ifdef NI_LATENCY_STATS_EN
    ,
    .o_total_latency (o_total_latency),
    .o_max_latency   (o_max_latency)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PktW-1:0] mk(input logic [15:0] pay, input logic [15:0] meas,
                                         input logic [3:0] ys, input logic [3:0] xs,
                                         input logic [3:0] yd, input logic [3:0] xd);
    return {pay, meas, ys, xs, yd, xd};
  endfunction

  // Reference time: cycles since reset release, modulo 2^TS_W.
  logic [TS_W-1:0] cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= '0;
    else          cyc <= cyc + 16'd1;
  end

  // Scoreboard state.
  logic [PktW-1:0] inj_q[$];
  logic [TS_W-1:0] wcyc_q[$];
  logic [PktW-1:0] hq[$];
  int unsigned     inj_m, ej_m;
  logic [TS_W-1:0] lat_m;
  logic            err_m;
  longint unsigned tot_m;
  logic [TS_W-1:0] max_m;

  task automatic clear_model();
    inj_q.delete(); wcyc_q.delete(); hq.delete();
    inj_m = 0; ej_m = 0; lat_m = '0; err_m = 1'b0; tot_m = 0; max_m = '0;
  endtask

  // Monitor: at the negedge, inputs and outputs are settled for the upcoming edge.
  always @(negedge clk) begin
    if (reset_n) begin
      logic [PktW-1:0] exp_p, d;
      logic [TS_W-1:0] w, l;
      logic            exp_en;
      chk("inj_count", o_inj_count, inj_m);
      if (inj_q.size() < DEPTH) chk("core_en_room", bus.o_core_en, 1'b1);
      if (inj_q.size() > DEPTH) chk("core_en_full", bus.o_core_en, 1'b0);
      if (bus.o_net_data_val && bus.i_net_en) begin
        if (inj_q.size() == 0) chk("inj_unexpected", 1, 0);
        else begin
          exp_p = inj_q.pop_front();
          w = wcyc_q.pop_front();
          chk("inj_data", bus.o_net_data, exp_p);
          chk("inj_min_latency", 64'((cyc - w) >= 16'd2), 1);
        end
        inj_m++;
      end
      if (bus.i_core_data_val && bus.o_core_en) begin
        d = bus.i_core_data;
        inj_q.push_back(mk(d[47:32], cyc, 4'(YL), 4'(XL), d[7:4], d[3:0]));
        wcyc_q.push_back(cyc);
      end

      exp_en = (hq.size() == 0) || bus.i_core_en;
      chk("net_en", bus.o_net_en, exp_en);
      chk("core_val", bus.o_core_data_val, 64'(hq.size() != 0));
      if (hq.size() != 0) chk("core_data", bus.o_core_data, hq[0]);
      chk("latency", o_latency, lat_m);
      chk("dest_err", o_dest_error, err_m);
      chk("ej_count", o_ej_count, ej_m);
`ifdef NI_LATENCY_STATS_EN
      chk("total_lat", o_total_latency, tot_m);
      chk("max_lat", o_max_latency, max_m);
`endif
      if (hq.size() != 0 && bus.i_core_en) begin
        void'(hq.pop_front());
        ej_m++;
      end
      if (bus.i_net_data_val && exp_en) begin
        d = bus.i_net_data;
        if (d[3:0] == 4'(XL) && d[7:4] == 4'(YL)) begin
          hq.push_back(d);
          l = cyc - d[31:16];
          lat_m = l;
          tot_m = tot_m + l;
          if (tot_m > 64'hFFFF_FFFF) tot_m = 64'hFFFF_FFFF;
          if (l > max_m) max_m = l;
        end else begin
          err_m = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_core_data = '0; bus.i_core_data_val = 1'b0; bus.i_net_en = 1'b1;
    bus.i_net_data = '0;  bus.i_net_data_val = 1'b0;  bus.i_core_en = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_en"}, bus.o_core_en, 1'b1);
    chk({tag, "_net_en"}, bus.o_net_en, 1'b1);
    chk({tag, "_net_val"}, bus.o_net_data_val, 1'b0);
    chk({tag, "_net_data"}, bus.o_net_data, '0);
    chk({tag, "_core_val"}, bus.o_core_data_val, 1'b0);
    chk({tag, "_core_data"}, bus.o_core_data, '0);
    chk({tag, "_lat"}, o_latency, '0);
    chk({tag, "_err"}, o_dest_error, 1'b0);
    chk({tag, "_counts"}, {o_inj_count, o_ej_count}, '0);
`ifdef NI_LATENCY_STATS_EN
    chk({tag, "_stats"}, {o_total_latency, o_max_latency}, '0);
`endif
  endtask

  task automatic eject(input logic [3:0] xd, input logic [3:0] yd, input logic [15:0] meas,
                       input logic [15:0] pay);
    bus.i_net_data = mk(pay, meas, 4'd0, 4'd0, yd, xd);
    bus.i_net_data_val = 1'b1;
    tick();
    bus.i_net_data_val = 1'b0;
  endtask

  initial begin
    logic [PktW-1:0] held;
    idle_inputs();
    clear_model();
    #2;
    check_reset_values("rst0");
    #10 reset_n = 1'b1;

    // Single injection at ts 5.
    while (cyc != 16'd5) tick();
    bus.i_core_data = mk(16'hBEEF, 16'h1234, 4'hF, 4'hF, 4'd2, 4'd1);
    bus.i_core_data_val = 1'b1;
    tick();
    bus.i_core_data_val = 1'b0;
    chk("inj1_not_yet", bus.o_net_data_val, 1'b0);
    tick();
    chk("inj1_val", bus.o_net_data_val, 1'b1);
    chk("inj1_pkt", bus.o_net_data, mk(16'hBEEF, 16'd5, 4'(YL), 4'(XL), 4'd2, 4'd1));
    tick();
    chk("inj1_count", o_inj_count, 1);

    // Ejection latency 15.
    while (cyc != 16'd25) tick();
    eject(4'(XL), 4'(YL), 16'd10, 16'h0A0A);
    chk("ej_lat15", o_latency, 16'd15);
    chk("ej_val", bus.o_core_data_val, 1'b1);
    tick();
    chk("ej_count1", o_ej_count, 1);

    // Wrong destination is dropped and flagged.
    eject(4'(XL + 1), 4'(YL), 16'd0, 16'h0BAD);
    chk("dest_err_set", o_dest_error, 1'b1);
    chk("dest_err_noval", bus.o_core_data_val, 1'b0);
    tick();
    chk("dest_err_sticky", o_dest_error, 1'b1);
    chk("dest_err_ejcnt", o_ej_count, 1);

    // Fill: one packet parked in the output register, then DEPTH writes.
    bus.i_net_en = 1'b0;
    bus.i_core_data = mk(16'h1000, 16'd0, 4'd0, 4'd0, 4'd5, 4'd6);
    bus.i_core_data_val = 1'b1;
    tick();
    bus.i_core_data_val = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_core_data = mk(16'h1001 + 16'(i), 16'd0, 4'd0, 4'd0, 4'(i), 4'(i + 1));
      bus.i_core_data_val = 1'b1;
      if (i == DEPTH - 1) chk("fill_en_before_last", bus.o_core_en, 1'b1);
      tick();
    end
    bus.i_core_data_val = 1'b0;
    chk("fill_full", bus.o_core_en, 1'b0);
    bus.i_net_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      chk("drain_b2b_val", bus.o_net_data_val, 1'b1);
      tick();
    end
    chk("drain_val_low", bus.o_net_data_val, 1'b0);
    chk("drain_en_high", bus.o_core_en, 1'b1);

    // Hold with core stalled, router attempts an ignored push, then reset mid-hold.
    bus.i_core_en = 1'b0;
    eject(4'(XL), 4'(YL), 16'd0, 16'hAAAA);
    chk("hold_val", bus.o_core_data_val, 1'b1);
    chk("hold_net_en", bus.o_net_en, 1'b0);
    held = bus.o_core_data;
    bus.i_net_data = mk(16'h5555, 16'd0, 4'd0, 4'd0, 4'(YL), 4'(XL));
    bus.i_net_data_val = 1'b1;
    tick();
    tick();
    chk("hold_stable", bus.o_core_data, held);
    chk("hold_net_en2", bus.o_net_en, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_reset_values("rst_mid");
    idle_inputs();
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Latencies 15 then 7.
    eject(4'(XL), 4'(YL), cyc - 16'd15, 16'h0001);
    eject(4'(XL), 4'(YL), cyc - 16'd7, 16'h0002);
    chk("lat7", o_latency, 16'd7);
`ifdef NI_LATENCY_STATS_EN
    chk("stats_total22", o_total_latency, 22);
    chk("stats_max15", o_max_latency, 15);
`endif

    // Timestamp wrap in the latency subtraction.
    while (cyc != 16'h0010) tick();
    eject(4'(XL), 4'(YL), 16'hFFF0, 16'h0003);
    chk("lat_wrap", o_latency, 16'h0020);

    // Randomized traffic on both sides.
    for (int n = 0; n < 800; n++) begin
      bus.i_core_data = mk(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                           4'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
      bus.i_core_data_val = ($urandom_range(0, 99) < 50);
      bus.i_net_en = ($urandom_range(0, 99) < 70);
      bus.i_net_data = mk(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 99) < 85) ? 4'(YL) : 4'($urandom),
                          ($urandom_range(0, 99) < 85) ? 4'(XL) : 4'($urandom));
      bus.i_net_data_val = ($urandom_range(0, 99) < 50);
      bus.i_core_en = ($urandom_range(0, 99) < 60);
      tick();
    end

    idle_inputs();
    for (int n = 0; n < 20; n++) tick();
    chk("drain_inj_empty", inj_q.size(), 0);
    chk("drain_ej_empty", hq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
